// File: rtl/hero_write_collector_pkg.sv
// Shared types and sizing for the hero write collector: bus beat format,
// buffered beat format and the transaction-assembly FSM states.
package hero_write_collector_pkg;

    localparam int HERO_WIDTH = 36;
    localparam int SUB_WIDTH  = 7;

    localparam int COLLECTOR_DEPTH           = 16;
    localparam int COLLECTOR_DEPTH_WIDTH     = $clog2(COLLECTOR_DEPTH);
    localparam int COLLECTOR_MAX_BEATS       = 8;
    localparam int COLLECTOR_MAX_BEATS_WIDTH = $clog2(COLLECTOR_MAX_BEATS);

    typedef logic [SUB_WIDTH-1:0] sub_def_t;

    // Bus cycle encoding; code 3 is reserved and treated as a protocol error.
    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_VALID = 2'd1,
        CYC_DONE  = 2'd2,
        CYC_RSVD  = 2'd3
    } cycle_type_e;

    // 46-bit hero write bus word as sampled every cycle.
    typedef struct packed {
        logic                  clk_en;
        cycle_type_e           cycle_type;
        sub_def_t              sub;
        logic [HERO_WIDTH-1:0] wdat;
    } hero_write_t;

    // One buffered beat; last marks the DONE beat of a transaction.
    typedef struct packed {
        logic                  last;
        sub_def_t              sub;
        logic [HERO_WIDTH-1:0] wdat;
    } hero_beat_t;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        IN_TXN = 2'd1,
        DROP   = 2'd2
    } collector_state_e;

endpackage

// File: rtl/hero_write_collector_beat_fifo.sv
// Store-and-forward beat buffer. Writes land at a speculative wr_ptr; only
// beats below cmt_ptr belong to whole transactions. A rewind throws away the
// open transaction by pulling wr_ptr back to the last commit point.
module hero_beat_fifo
    import hero_write_collector_pkg::*;
#(
    parameter int DEPTH = COLLECTOR_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  hero_beat_t push_beat,
    input  logic       commit,
    input  logic       rewind,
    input  logic       pop,
    output logic       full,
    output hero_beat_t rd_beat
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t FULL_OCC = ptr_t'(DEPTH);

    hero_beat_t mem [DEPTH];
    ptr_t       wr_ptr;
    ptr_t       cmt_ptr;
    ptr_t       rd_ptr;
    ptr_t       occ;

    // Occupancy counts speculative beats too, so an open transaction can
    // overflow the buffer; uses start-of-cycle pointers only.
    assign occ     = wr_ptr - rd_ptr;
    assign full    = (occ == FULL_OCC);
    assign rd_beat = mem[rd_ptr[AW-1:0]];

    // Beat storage; contents are meaningless until covered by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_beat;
        end
    end

    // Pointer updates; rewind wins over a push in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            rd_ptr  <= '0;
        end else begin
            if (rewind) begin
                wr_ptr <= cmt_ptr;
            end else if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            // Commit always accompanies the push of the DONE beat.
            if (commit) begin
                cmt_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

endmodule

// File: rtl/hero_write_collector.sv
// Consumer stage of the hero write bus. Assembles VALID..DONE beat runs into
// transactions, buffers them whole and releases beats on a valid/ready
// stream only once a transaction is committed. Overflowing or over-long
// transactions are dropped atomically and flagged with sticky errors.
module hero_write_collector
    import hero_write_collector_pkg::*;
#(
    parameter int DEPTH     = COLLECTOR_DEPTH,
    parameter int MAX_BEATS = COLLECTOR_MAX_BEATS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  hero_write_t                    hero_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [HERO_WIDTH-1:0]          out_wdat,
    output sub_def_t                       out_sub,
    output logic                           out_last,
    output logic [$clog2(MAX_BEATS)-1:0]   out_beat_idx,
    output logic [$clog2(DEPTH+1)-1:0]     pkt_count,
    output logic                           overflow_err,
    output logic                           proto_err,
    input  logic                           err_clr
);

    localparam int BW = $clog2(MAX_BEATS);
    localparam int CW = $clog2(DEPTH+1);

    typedef logic [BW-1:0] beat_t;
    typedef logic [CW-1:0] cnt_t;
    localparam beat_t LAST_IDX = beat_t'(MAX_BEATS - 1);

    collector_state_e state;
    collector_state_e state_nxt;

    beat_t      beat_cnt;
    hero_beat_t push_beat;
    hero_beat_t rd_beat;
    logic       full;
    logic       is_valid;
    logic       is_done;
    logic       accept;
    logic       illegal;
    logic       live;
    logic       len_viol;
    logic       violation;
    logic       push;
    logic       commit;
    logic       rewind;
    logic       ovf_set;
    logic       proto_set;
    logic       pop;
    logic       pop_last;

    // Input decode. beat_cnt is zero outside IN_TXN, so the length check
    // only ever fires on the MAX_BEATS-th beat of an open transaction.
    assign is_valid  = hero_in.clk_en && (hero_in.cycle_type == CYC_VALID);
    assign is_done   = hero_in.clk_en && (hero_in.cycle_type == CYC_DONE);
    assign illegal   = hero_in.clk_en && (hero_in.cycle_type == CYC_RSVD);
    assign accept    = is_valid || is_done;
    assign live      = accept && (state != DROP);
    assign len_viol  = is_valid && (beat_cnt == LAST_IDX);
    assign violation = live && (full || len_viol);

    assign push_beat = '{last: is_done, sub: hero_in.sub, wdat: hero_in.wdat};

    hero_beat_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_beat (push_beat),
        .commit    (commit),
        .rewind    (rewind),
        .pop       (pop),
        .full      (full),
        .rd_beat   (rd_beat)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE_S;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state. A violating DONE closes the transaction immediately,
    // a violating VALID leaves the rest of it to be swallowed in DROP.
    always_comb begin
        state_nxt = state;
        if (violation) begin
            state_nxt = is_done ? IDLE_S : DROP;
        end else begin
            unique case (state)
                IDLE_S: if (is_valid) state_nxt = IN_TXN;
                IN_TXN: if (is_done)  state_nxt = IDLE_S;
                DROP:   if (is_done)  state_nxt = IDLE_S;
                default:              state_nxt = IDLE_S;
            endcase
        end
    end

    // FSM outputs: buffer controls and error set strobes.
    always_comb begin
        push      = live && !violation;
        commit    = live && !violation && is_done;
        rewind    = violation;
        ovf_set   = live && full;
        proto_set = illegal || (live && len_viol);
    end

    // Beats stored so far in the open transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (rewind || commit) begin
            beat_cnt <= '0;
        end else if (push) begin
            beat_cnt <= beat_cnt + beat_t'(1);
        end
    end

    // Read side: a committed transaction is presented straight from the
    // buffer head; data holds while the consumer stalls.
    assign out_valid = (pkt_count != '0);
    assign out_wdat  = rd_beat.wdat;
    assign out_sub   = rd_beat.sub;
    assign out_last  = rd_beat.last;
    assign pop       = out_valid && out_ready;
    assign pop_last  = pop && rd_beat.last;

    // Beat index within the transaction being delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_beat_idx <= '0;
        end else if (pop_last) begin
            out_beat_idx <= '0;
        end else if (pop) begin
            out_beat_idx <= out_beat_idx + beat_t'(1);
        end
    end

    // Whole transactions buffered: up on commit, down on the last beat out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
        end else begin
            unique case ({commit, pop_last})
                2'b10:   pkt_count <= pkt_count + cnt_t'(1);
                2'b01:   pkt_count <= pkt_count - cnt_t'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // Sticky errors; a same-cycle set beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
            if (proto_set) begin
                proto_err <= 1'b1;
            end else if (err_clr) begin
                proto_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hero_write_collector.sv
// Directed bench for hero_write_collector: a vector table for the basic
// streaming and ignore/illegal-cycle cases, plus hand sequences for stall,
// overflow, over-length and mid-transaction reset.
module tb_hero_write_collector;
    import hero_write_collector_pkg::*;

    localparam logic [1:0] IDL = 2'd0;
    localparam logic [1:0] VAL = 2'd1;
    localparam logic [1:0] DON = 2'd2;
    localparam logic [1:0] BAD = 2'd3;

    logic        clk;
    logic        rst;
    hero_write_t hero_in;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_wdat;
    sub_def_t    out_sub;
    logic        out_last;
    logic [2:0]  out_beat_idx;
    logic [4:0]  pkt_count;
    logic        overflow_err;
    logic        proto_err;
    logic        err_clr;

    int checks;
    int errors;

    hero_write_collector dut (
        .clk          (clk),
        .rst          (rst),
        .hero_in      (hero_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_wdat     (out_wdat),
        .out_sub      (out_sub),
        .out_last     (out_last),
        .out_beat_idx (out_beat_idx),
        .pkt_count    (pkt_count),
        .overflow_err (overflow_err),
        .proto_err    (proto_err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  ct;
        logic [35:0] w;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [35:0] e_wdat;
        logic        e_last;
        logic [2:0]  e_idx;
        logic [4:0]  e_cnt;
        logic        e_ovf;
        logic        e_proto;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic en, input logic [1:0] ct, input logic [35:0] w,
                                input logic rdy, input logic clr, input logic ev,
                                input logic [35:0] ew, input logic el, input logic [2:0] ei,
                                input logic [4:0] ec, input logic eo, input logic ep);
        vec_t v;
        v.en = en; v.ct = ct; v.w = w; v.rdy = rdy; v.clr = clr;
        v.e_valid = ev; v.e_wdat = ew; v.e_last = el; v.e_idx = ei;
        v.e_cnt = ec; v.e_ovf = eo; v.e_proto = ep;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] ct, input logic [35:0] w,
                         input logic rdy, input logic clr);
        hero_in.clk_en     = en;
        hero_in.cycle_type = cycle_type_e'(ct);
        hero_in.sub        = w[6:0];
        hero_in.wdat       = w;
        out_ready          = rdy;
        err_clr            = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares the state-derived outputs; data fields only when a beat is shown.
    task automatic chk_out(input string n, input logic ev, input logic [35:0] ew,
                           input logic el, input logic [2:0] ei, input logic [4:0] ec,
                           input logic eo, input logic ep);
        chk({n, ".valid"}, 64'(out_valid), 64'(ev));
        if (ev) begin
            chk({n, ".wdat"}, 64'(out_wdat), 64'(ew));
            chk({n, ".sub"},  64'(out_sub),  64'(ew[6:0]));
            chk({n, ".last"}, 64'(out_last), 64'(el));
        end
        chk({n, ".idx"},   64'(out_beat_idx), 64'(ei));
        chk({n, ".count"}, 64'(pkt_count),    64'(ec));
        chk({n, ".ovf"},   64'(overflow_err), 64'(eo));
        chk({n, ".proto"}, 64'(proto_err),    64'(ep));
    endtask

    // Sends one idle cycle with ready high and expects the given beat to be taken.
    task automatic take_beat(input string n, input logic [35:0] ew, input logic el,
                             input logic [2:0] ei, input logic [4:0] ec);
        drive(1'b0, IDL, 36'h0, 1'b1, 1'b0);
        #1;
        chk_out(n, 1'b1, ew, el, ei, ec, overflow_err, proto_err);
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        logic [35:0] ew;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, IDL, 36'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_out("reset", 1'b0, 36'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        tick();

        // Streaming transaction, then ignored/idle cycles inside another one,
        // then a reserved cycle type and its clear.
        add(1, VAL, 36'h1,   1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(1, VAL, 36'h2,   1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(1, DON, 36'h3,   1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(0, IDL, 36'h0,   1, 0,  1, 36'h1, 0, 0, 1, 0, 0);
        add(0, IDL, 36'h0,   1, 0,  1, 36'h2, 0, 1, 1, 0, 0);
        add(0, IDL, 36'h0,   1, 0,  1, 36'h3, 1, 2, 1, 0, 0);
        add(0, IDL, 36'h0,   1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(1, VAL, 36'hA,   1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(0, VAL, 36'hBAD, 1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(1, IDL, 36'hBAD, 1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(1, VAL, 36'hB,   1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(1, DON, 36'hC,   1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(0, IDL, 36'h0,   1, 0,  1, 36'hA, 0, 0, 1, 0, 0);
        add(0, DON, 36'hBAD, 1, 0,  1, 36'hB, 0, 1, 1, 0, 0);
        add(0, IDL, 36'h0,   1, 0,  1, 36'hC, 1, 2, 1, 0, 0);
        add(0, IDL, 36'h0,   1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(1, BAD, 36'hBAD, 1, 0,  0, 36'h0, 0, 0, 0, 0, 0);
        add(0, IDL, 36'h0,   1, 0,  0, 36'h0, 0, 0, 0, 0, 1);
        add(0, IDL, 36'h0,   1, 1,  0, 36'h0, 0, 0, 0, 0, 1);
        add(0, IDL, 36'h0,   1, 0,  0, 36'h0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].ct, vecs[i].w, vecs[i].rdy, vecs[i].clr);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_wdat, vecs[i].e_last,
                    vecs[i].e_idx, vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_proto);
            tick();
        end

        // Single-DONE transaction held under backpressure.
        drive(1'b1, DON, 36'h55, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, IDL, 36'h0, 1'b0, 1'b0);
            #1;
            chk_out($sformatf("stall%0d", c), 1'b1, 36'h55, 1'b1, 3'd0, 5'd1, 1'b0, 1'b0);
            tick();
        end
        take_beat("stall.take", 36'h55, 1'b1, 3'd0, 5'd1);
        drive(1'b0, IDL, 36'h0, 1'b0, 1'b0);
        #1;
        chk_out("stall.after", 1'b0, 36'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        tick();

        // Two full-length transactions fill the buffer; the third is dropped.
        for (int t = 1; t <= 2; t++) begin
            for (int i = 0; i < 8; i++) begin
                drive(1'b1, (i == 7) ? DON : VAL, 36'(t * 256 + i), 1'b0, 1'b0);
                tick();
            end
        end
        drive(1'b1, DON, 36'h99, 1'b0, 1'b0);
        tick();
        drive(1'b0, IDL, 36'h0, 1'b0, 1'b0);
        #1;
        chk_out("ovf.state", 1'b1, 36'h100, 1'b0, 3'd0, 5'd2, 1'b1, 1'b0);
        drive(1'b0, IDL, 36'h0, 1'b1, 1'b0);
        #1;
        n = 0;
        for (int c = 0; c < 40 && out_valid; c++) begin
            ew = (n < 8) ? 36'(256 + n) : 36'(512 + n - 8);
            chk($sformatf("ovf.beat%0d.wdat", n), 64'(out_wdat), 64'(ew));
            chk($sformatf("ovf.beat%0d.last", n), 64'(out_last), 64'((n % 8) == 7));
            chk($sformatf("ovf.beat%0d.idx", n),  64'(out_beat_idx), 64'(n % 8));
            n++;
            tick();
        end
        chk("ovf.beats", 64'(n), 64'd16);
        chk("ovf.count", 64'(pkt_count), 64'd0);
        drive(1'b0, IDL, 36'h0, 1'b1, 1'b1);
        tick();
        drive(1'b0, IDL, 36'h0, 1'b1, 1'b0);
        #1;
        chk("ovf.cleared", 64'(overflow_err), 64'd0);

        // Over-length transaction: 8th VALID beat is a protocol error.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, VAL, 36'(48 + i), 1'b1, 1'b0);
            #1;
            chk($sformatf("len.pre%0d.proto", i), 64'(proto_err), 64'd0);
            tick();
        end
        chk("len.proto", 64'(proto_err), 64'd1);
        drive(1'b1, DON, 36'h77, 1'b1, 1'b1);
        tick();
        drive(1'b0, IDL, 36'h0, 1'b1, 1'b0);
        #1;
        chk_out("len.dropped", 1'b0, 36'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, VAL, 36'h21, 1'b1, 1'b0);
        tick();
        drive(1'b1, DON, 36'h22, 1'b1, 1'b0);
        tick();
        take_beat("len.next0", 36'h21, 1'b0, 3'd0, 5'd1);
        take_beat("len.next1", 36'h22, 1'b1, 3'd1, 5'd1);

        // Reset in the middle of an open transaction with an error pending.
        drive(1'b1, BAD, 36'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, VAL, 36'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, VAL, 36'h12, 1'b0, 1'b0);
        tick();
        drive(1'b0, IDL, 36'h0, 1'b0, 1'b0);
        chk("rst.pre.proto", 64'(proto_err), 64'd1);
        rst = 1'b1;
        #2;
        chk_out("rst.mid", 1'b0, 36'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        drive(1'b1, VAL, 36'h31, 1'b1, 1'b0);
        tick();
        drive(1'b1, VAL, 36'h32, 1'b1, 1'b0);
        tick();
        drive(1'b1, DON, 36'h33, 1'b1, 1'b0);
        tick();
        take_beat("rst.beat0", 36'h31, 1'b0, 3'd0, 5'd1);
        take_beat("rst.beat1", 36'h32, 1'b0, 3'd1, 5'd1);
        take_beat("rst.beat2", 36'h33, 1'b1, 3'd2, 5'd1);
        drive(1'b0, IDL, 36'h0, 1'b1, 1'b0);
        #1;
        chk_out("rst.done", 1'b0, 36'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
